// File: rtl/arbitro_serial_pkg.sv
// Shared constants and types for the round-robin serial lane arbiter.
// The comma byte is the same K28.5 symbol the serializer uses for idle.
package arbitro_serial_pkg;

  localparam int         NUM_LANES  = 4;
  localparam int         LANE_W     = 2;
  localparam logic [7:0] COMMA_K285 = 8'hBC;

  typedef enum logic {
    ST_INIT,
    ST_ACTIVE
  } arb_state_t;

  // Lane that follows the given one in round-robin order (wraps 3 -> 0).
  function automatic logic [LANE_W-1:0] next_lane(input logic [LANE_W-1:0] lane);
    return lane + 1'b1;
  endfunction

endpackage

// File: rtl/arbitro_serial_fifo_carril.sv
// Per-lane synchronous byte FIFO. The head entry is visible on dout
// combinationally, so a byte written at one edge can be popped at the next.
module fifo_carril #(
  parameter int DEPTH = 4
) (
  input  logic                     clk_4f,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int             AW      = $clog2(DEPTH);
  localparam logic [AW:0]    DEPTH_C = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Storage array; left without reset since count/pointers define validity.
  always_ff @(posedge clk_4f) begin
    if (!reset && push_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally at a power-of-two depth; count tracks occupancy.
  always_ff @(posedge clk_4f) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/arbitro_serial.sv
// Round-robin scheduler feeding one serializer lane from four byte sources.
// After reset a short comma-only INIT phase lets the receiver lock before
// buffered payload starts flowing, one byte per clk_4f cycle.
module arbitro_serial
  import arbitro_serial_pkg::*;
#(
  parameter int         FIFO_DEPTH = 4,
  parameter int         INIT_WORDS = 4,
  parameter logic [7:0] COMMA      = COMMA_K285
) (
  input  logic                  clk_4f,
  input  logic                  reset,
  input  logic [NUM_LANES-1:0]  valid_in,
  input  logic [8*NUM_LANES-1:0] data_in,
  output logic [NUM_LANES-1:0]  full,
  output logic [NUM_LANES-1:0]  overflow,
  output logic [7:0]            data_out,
  output logic                  valid_out,
  output logic [LANE_W-1:0]     lane_id,
  output logic                  active
);

  localparam int                CW        = $clog2(FIFO_DEPTH);
  localparam int                INIT_CW   = (INIT_WORDS > 1) ? $clog2(INIT_WORDS) : 1;
  localparam logic [INIT_CW-1:0] INIT_LAST = INIT_CW'(INIT_WORDS - 1);

  arb_state_t          state;
  arb_state_t          next_state;
  logic [INIT_CW-1:0]  init_cnt;
  logic [LANE_W-1:0]   rr_ptr;

  logic [7:0]          lane_dout  [NUM_LANES];
  logic [CW:0]         lane_count [NUM_LANES];
  logic [NUM_LANES-1:0] lane_empty;

  logic                grant_valid;
  logic [LANE_W-1:0]   grant_lane;
  logic [NUM_LANES-1:0] grant_vec;

  for (genvar n = 0; n < NUM_LANES; n++) begin : g_lane
    fifo_carril #(
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk_4f (clk_4f),
      .reset  (reset),
      .push   (valid_in[n]),
      .pop    (grant_vec[n] & ~lane_empty[n]),
      .din    (data_in[8*n +: 8]),
      .dout   (lane_dout[n]),
      .count  (lane_count[n]),
      .full   (full[n]),
      .empty  (lane_empty[n])
    );
  end

  assign active = (state == ST_ACTIVE);

  // State register and INIT word counter.
  always_ff @(posedge clk_4f) begin
    if (reset) begin
      state    <= ST_INIT;
      init_cnt <= '0;
    end else begin
      state <= next_state;
      if (state == ST_INIT && init_cnt != INIT_LAST) begin
        init_cnt <= init_cnt + 1'b1;
      end
    end
  end

  // Leave INIT after the last comma word has been spent.
  always_comb begin
    next_state = state;
    case (state)
      ST_INIT:   if (init_cnt == INIT_LAST) next_state = ST_ACTIVE;
      ST_ACTIVE: next_state = ST_ACTIVE;
      default:   next_state = ST_INIT;
    endcase
  end

  // Round-robin search from rr_ptr for the first lane holding data.
  always_comb begin
    logic              found;
    logic [LANE_W-1:0] cand;
    found       = 1'b0;
    cand        = rr_ptr;
    grant_lane  = rr_ptr;
    for (int i = 0; i < NUM_LANES; i++) begin
      cand = rr_ptr + LANE_W'(i);
      if (!found && lane_count[cand] != '0) begin
        found      = 1'b1;
        grant_lane = cand;
      end
    end
    grant_valid = found && (state == ST_ACTIVE);
    grant_vec   = grant_valid ? (NUM_LANES'(1) << grant_lane) : '0;
  end

  // Output registers and pointer advance; idle cycles carry the comma.
  always_ff @(posedge clk_4f) begin
    if (reset) begin
      data_out  <= COMMA;
      valid_out <= 1'b0;
      lane_id   <= '0;
      rr_ptr    <= '0;
    end else if (grant_valid) begin
      data_out  <= lane_dout[grant_lane];
      valid_out <= 1'b1;
      lane_id   <= grant_lane;
      rr_ptr    <= next_lane(grant_lane);
    end else begin
      data_out  <= COMMA;
      valid_out <= 1'b0;
      lane_id   <= '0;
    end
  end

  // Sticky flag for pushes lost to a full lane.
  always_ff @(posedge clk_4f) begin
    if (reset) begin
      overflow <= '0;
    end else begin
      overflow <= overflow | (valid_in & full);
    end
  end

endmodule

// File: tb/tb_arbitro_serial.sv
// Self-checking bench for arbitro_serial: directed scenarios plus random
// traffic, compared every cycle against a queue-based reference model.
module tb_arbitro_serial;

  logic        clk_4f = 1'b0;
  logic        reset;
  logic [3:0]  valid_in;
  logic [31:0] data_in;
  logic [3:0]  full;
  logic [3:0]  overflow;
  logic [7:0]  data_out;
  logic        valid_out;
  logic [1:0]  lane_id;
  logic        active;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [7:0] mq [4][$];
  int         m_ptr;
  int         m_cycles;
  logic [3:0] m_ovf;
  logic [7:0] m_data;
  logic       m_valid;
  logic [1:0] m_lane;

  arbitro_serial dut (
    .clk_4f    (clk_4f),
    .reset     (reset),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .full      (full),
    .overflow  (overflow),
    .data_out  (data_out),
    .valid_out (valid_out),
    .lane_id   (lane_id),
    .active    (active)
  );

  // Free-running byte clock
  always #5 clk_4f = ~clk_4f;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance the reference model by one clock edge using the driven inputs.
  task automatic modelEdge(input logic r, input logic [3:0] v, input logic [31:0] d);
    logic [3:0] full_before;
    int g;
    if (r) begin
      for (int n = 0; n < 4; n++) mq[n].delete();
      m_ptr = 0; m_cycles = 0; m_ovf = '0;
      m_data = 8'hBC; m_valid = 1'b0; m_lane = 2'd0;
    end else begin
      for (int n = 0; n < 4; n++) full_before[n] = (mq[n].size() == 4);
      g = -1;
      if (m_cycles >= 4) begin
        for (int k = 0; k < 4; k++) begin
          if (g < 0 && mq[(m_ptr + k) % 4].size() > 0) g = (m_ptr + k) % 4;
        end
      end
      if (g >= 0) begin
        m_data  = mq[g].pop_front();
        m_valid = 1'b1;
        m_lane  = 2'(g);
        m_ptr   = (g + 1) % 4;
      end else begin
        m_data = 8'hBC; m_valid = 1'b0; m_lane = 2'd0;
      end
      for (int n = 0; n < 4; n++) begin
        if (v[n]) begin
          if (full_before[n]) m_ovf[n] = 1'b1;
          else mq[n].push_back(d[8*n +: 8]);
        end
      end
      if (m_cycles < 4) m_cycles++;
    end
  endtask

  task automatic checkOutput(input string tag);
    logic [3:0] efull;
    for (int n = 0; n < 4; n++) efull[n] = (mq[n].size() == 4);
    chk({tag, "_data"},   32'(data_out),  32'(m_data));
    chk({tag, "_valid"},  32'(valid_out), 32'(m_valid));
    chk({tag, "_lane"},   32'(lane_id),   32'(m_lane));
    chk({tag, "_active"}, 32'(active),    32'(m_cycles >= 4));
    chk({tag, "_full"},   32'(full),      32'(efull));
    chk({tag, "_ovf"},    32'(overflow),  32'(m_ovf));
  endtask

  task automatic applyStimulus(input string tag, input logic r, input logic [3:0] v,
                               input logic [31:0] d);
    reset    = r;
    valid_in = v;
    data_in  = d;
    @(posedge clk_4f);
    modelEdge(r, v, d);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    reset = 1'b1; valid_in = '0; data_in = '0;
    m_ptr = 0; m_cycles = 0; m_ovf = '0; m_data = 8'hBC; m_valid = 1'b0; m_lane = 2'd0;

    // Test 1: reset then idle through INIT
    applyStimulus("t1_rst", 1'b1, 4'h0, 32'h0);
    applyStimulus("t1_rst", 1'b1, 4'h0, 32'h0);
    chk("t1_rst_active", 32'(active), 32'd0);
    chk("t1_rst_data", 32'(data_out), 32'hBC);
    for (int i = 0; i < 3; i++) applyStimulus("t1_init", 1'b0, 4'h0, 32'h0);
    chk("t1_still_init", 32'(active), 32'd0);
    applyStimulus("t1_init", 1'b0, 4'h0, 32'h0);
    chk("t1_active_up", 32'(active), 32'd1);
    chk("t1_idle_data", 32'(data_out), 32'hBC);
    chk("t1_idle_valid", 32'(valid_out), 32'd0);

    // Test 2: three bytes on lane 2
    applyStimulus("t2", 1'b0, 4'b0100, 32'h0011_0000);
    applyStimulus("t2", 1'b0, 4'b0100, 32'h0022_0000);
    chk("t2_first", 32'({valid_out, lane_id, data_out}), 32'({1'b1, 2'd2, 8'h11}));
    applyStimulus("t2", 1'b0, 4'b0100, 32'h0033_0000);
    chk("t2_second", 32'(data_out), 32'h22);
    applyStimulus("t2", 1'b0, 4'h0, 32'h0);
    chk("t2_third", 32'(data_out), 32'h33);
    applyStimulus("t2", 1'b0, 4'h0, 32'h0);
    chk("t2_idle", 32'({valid_out, data_out}), 32'({1'b0, 8'hBC}));

    // Move pointer back to lane 0 via a single lane-3 byte
    applyStimulus("t3_pre", 1'b0, 4'b1000, 32'h7700_0000);
    applyStimulus("t3_pre", 1'b0, 4'h0, 32'h0);
    applyStimulus("t3_pre", 1'b0, 4'h0, 32'h0);

    // Test 3: all four lanes in one cycle
    applyStimulus("t3", 1'b0, 4'b1111, 32'hD3C2_B1A0);
    applyStimulus("t3", 1'b0, 4'h0, 32'h0);
    chk("t3_lane0", 32'({lane_id, data_out}), 32'({2'd0, 8'hA0}));
    applyStimulus("t3", 1'b0, 4'h0, 32'h0);
    chk("t3_lane1", 32'({lane_id, data_out}), 32'({2'd1, 8'hB1}));
    applyStimulus("t3", 1'b0, 4'h0, 32'h0);
    chk("t3_lane2", 32'({lane_id, data_out}), 32'({2'd2, 8'hC2}));
    applyStimulus("t3", 1'b0, 4'h0, 32'h0);
    chk("t3_lane3", 32'({lane_id, data_out}), 32'({2'd3, 8'hD3}));
    applyStimulus("t3", 1'b0, 4'h0, 32'h0);

    // Test 4: lane 0 streaming, lane 3 injects one byte
    for (int i = 0; i < 12; i++) begin
      if (i == 3) applyStimulus("t4", 1'b0, 4'b1001, {8'h5A, 16'h0, 8'(8'h40 + i)});
      else        applyStimulus("t4", 1'b0, 4'b0001, {24'h0, 8'(8'h40 + i)});
    end
    for (int i = 0; i < 4; i++) applyStimulus("t4_drain", 1'b0, 4'h0, 32'h0);

    // Test 5: fill lane 1 during INIT, fifth push overflows
    applyStimulus("t5_rst", 1'b1, 4'h0, 32'h0);
    for (int i = 0; i < 4; i++) applyStimulus("t5_push", 1'b0, 4'b0010, {16'h0, 8'(8'h90 + i), 8'h0});
    chk("t5_full", 32'(full[1]), 32'd1);
    chk("t5_no_ovf", 32'(overflow[1]), 32'd0);
    applyStimulus("t5_push5", 1'b0, 4'b0010, 32'h0000_FF00);
    chk("t5_ovf", 32'(overflow[1]), 32'd1);
    chk("t5_first_out", 32'(data_out), 32'h90);
    for (int i = 0; i < 6; i++) applyStimulus("t5_drain", 1'b0, 4'h0, 32'h0);

    // Test 6: reset while lanes 0/1 hold data
    applyStimulus("t6_load", 1'b0, 4'b0011, 32'h0000_2121);
    applyStimulus("t6_load", 1'b0, 4'b0011, 32'h0000_3131);
    applyStimulus("t6_load", 1'b0, 4'b0011, 32'h0000_4141);
    applyStimulus("t6_rst", 1'b1, 4'h0, 32'h0);
    chk("t6_rst_out", 32'({valid_out, data_out}), 32'({1'b0, 8'hBC}));
    chk("t6_rst_flags", 32'({full, overflow, active}), 32'd0);
    for (int i = 0; i < 10; i++) applyStimulus("t6_after", 1'b0, 4'h0, 32'h0);
    chk("t6_no_stale", 32'(valid_out), 32'd0);

    // Random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      applyStimulus("rnd", ($urandom_range(0, 59) == 0), 4'($urandom), $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
